// File: rtl/axi_mem_arbiter.sv
// 2:1 AXI4-Lite arbiter: IFU + LSU reads share one AR/R port, LSU writes are tracked through AW/W/B.
// Optional macro ARB_ROUND_ROBIN_EN swaps the LSU-priority read tie-break for alternating grants.
module axi_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // IFU read master
    input  logic              ifu_arvalid,
    input  logic              ifu_rready,
    input  logic [AW-1:0]     ifu_araddr,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    output logic [DW-1:0]     ifu_rdata,
    output logic [1:0]        ifu_rresp,
    // LSU read master
    input  logic              lsu_arvalid,
    input  logic              lsu_rready,
    input  logic [AW-1:0]     lsu_araddr,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    output logic [DW-1:0]     lsu_rdata,
    output logic [1:0]        lsu_rresp,
    // LSU write master
    input  logic              lsu_awvalid,
    input  logic              lsu_wvalid,
    input  logic              lsu_bready,
    input  logic [AW-1:0]     lsu_awaddr,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wstrb,
    output logic              lsu_awready,
    output logic              lsu_wready,
    output logic              lsu_bvalid,
    output logic [1:0]        lsu_bresp,
    // XBAR-side master port
    output logic              arvalid,
    output logic              rready,
    output logic              awvalid,
    output logic              wvalid,
    output logic              bready,
    output logic [AW-1:0]     araddr,
    output logic [AW-1:0]     awaddr,
    output logic [DW-1:0]     wdata,
    output logic [DW/8-1:0]   wstrb,
    input  logic              arready,
    input  logic              rvalid,
    input  logic              awready,
    input  logic              wready,
    input  logic              bvalid,
    input  logic [1:0]        rresp,
    input  logic [1:0]        bresp,
    input  logic [DW-1:0]     rdata,
    // FSM state observation
    output logic [2:0]        o_dbg_r_state,
    output logic [1:0]        o_dbg_w_state
);

    // Handshake rule on every channel: a beat transfers in the cycle where
    // valid && ready are both high at the rising edge; valid never waits on ready.

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_IFU  = 3'd1,
        R_LSU  = 3'd2,
        R_AR   = 3'd3,
        R_DATA = 3'd4
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    r_state_t r_rstate, w_rstate_nxt;
    w_state_t r_wstate, w_wstate_nxt;

    logic r_grant_lsu;
    logic r_aw_done;
    logic r_w_done;
    logic w_rd_req;
    logic w_pick_lsu;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_b_fire;

    assign w_rd_req = ifu_arvalid | lsu_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;  // 1 = LSU won the most recent grant

    assign w_pick_lsu = lsu_arvalid & (~ifu_arvalid | ~r_last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (r_rstate == R_IDLE && w_rd_req) begin
            r_last_grant <= w_pick_lsu;
        end
    end
`else
    assign w_pick_lsu = lsu_arvalid;
`endif

    // ---------------- read path ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate    <= R_IDLE;
            r_grant_lsu <= 1'b1;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (r_rstate == R_IDLE && w_rd_req) begin
                r_grant_lsu <= w_pick_lsu;
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        arvalid      = 1'b0;
        araddr       = '0;
        rready       = 1'b0;
        ifu_arready  = 1'b0;
        lsu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        ifu_rdata    = '0;
        ifu_rresp    = 2'b00;
        lsu_rvalid   = 1'b0;
        lsu_rdata    = '0;
        lsu_rresp    = 2'b00;
        case (r_rstate)
            R_IDLE: begin
                if (w_rd_req) begin
                    w_rstate_nxt = w_pick_lsu ? R_LSU : R_IFU;
                end
            end
            R_IFU, R_LSU: begin
                w_rstate_nxt = R_AR;
            end
            R_AR: begin
                // A master that withdraws arvalid simply stalls the FSM here.
                if (r_grant_lsu) begin
                    arvalid     = lsu_arvalid;
                    araddr      = lsu_araddr;
                    lsu_arready = arready;
                end else begin
                    arvalid     = ifu_arvalid;
                    araddr      = ifu_araddr;
                    ifu_arready = arready;
                end
                if (arvalid && arready) begin
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (r_grant_lsu) begin
                    lsu_rvalid = rvalid;
                    lsu_rdata  = rdata;
                    lsu_rresp  = rresp;
                    rready     = lsu_rready;
                end else begin
                    ifu_rvalid = rvalid;
                    ifu_rdata  = rdata;
                    ifu_rresp  = rresp;
                    rready     = ifu_rready;
                end
                if (rvalid && rready) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // ---------------- write path ----------------
    assign w_aw_fire = awvalid & awready;
    assign w_w_fire  = wvalid & wready;
    assign w_b_fire  = bvalid & bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (r_wstate == W_RESP && w_b_fire) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_wstate == W_ADDR) begin
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        awvalid      = 1'b0;
        awaddr       = '0;
        wvalid       = 1'b0;
        wdata        = '0;
        wstrb        = '0;
        bready       = 1'b0;
        lsu_awready  = 1'b0;
        lsu_wready   = 1'b0;
        lsu_bvalid   = 1'b0;
        lsu_bresp    = 2'b00;
        case (r_wstate)
            W_IDLE: begin
                if (lsu_awvalid) begin
                    w_wstate_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                // Each channel completes once; its valid is masked after that beat.
                awvalid     = lsu_awvalid & ~r_aw_done;
                awaddr      = lsu_awaddr;
                lsu_awready = awready & ~r_aw_done;
                wvalid      = lsu_wvalid & ~r_w_done;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                lsu_wready  = wready & ~r_w_done;
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                lsu_bvalid = bvalid;
                lsu_bresp  = bresp;
                bready     = lsu_bready;
                if (w_b_fire) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    assign o_dbg_r_state = r_rstate;
    assign o_dbg_w_state = r_wstate;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: table-driven single reads, hand-written tie, reset and write sequences.
module tb_axi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk, rst_n;
  logic ifu_arvalid, ifu_rready, ifu_arready, ifu_rvalid;
  logic [AW-1:0] ifu_araddr;
  logic [DW-1:0] ifu_rdata;
  logic [1:0] ifu_rresp;
  logic lsu_arvalid, lsu_rready, lsu_arready, lsu_rvalid;
  logic [AW-1:0] lsu_araddr;
  logic [DW-1:0] lsu_rdata;
  logic [1:0] lsu_rresp;
  logic lsu_awvalid, lsu_wvalid, lsu_bready;
  logic [AW-1:0] lsu_awaddr;
  logic [DW-1:0] lsu_wdata;
  logic [SW-1:0] lsu_wstrb;
  logic lsu_awready, lsu_wready, lsu_bvalid;
  logic [1:0] lsu_bresp;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic [AW-1:0] araddr, awaddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic arready, rvalid, awready, wready, bvalid;
  logic [1:0] rresp, bresp;
  logic [DW-1:0] rdata;
  logic [2:0] dbg_r;
  logic [1:0] dbg_w;

  axi_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_rready(ifu_rready), .ifu_araddr(ifu_araddr),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_rready(lsu_rready), .lsu_araddr(lsu_araddr),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_awvalid(lsu_awvalid), .lsu_wvalid(lsu_wvalid), .lsu_bready(lsu_bready),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_awready(lsu_awready), .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp),
    .arvalid(arvalid), .rready(rready), .awvalid(awvalid), .wvalid(wvalid), .bready(bready),
    .araddr(araddr), .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
    .arready(arready), .rvalid(rvalid), .awready(awready), .wready(wready), .bvalid(bvalid),
    .rresp(rresp), .bresp(bresp), .rdata(rdata),
    .o_dbg_r_state(dbg_r), .o_dbg_w_state(dbg_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  int aw_beats = 0;
  int w_beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (awvalid && awready) aw_beats++;
    if (wvalid && wready) w_beats++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serves one read whose requests are already driven; drops only the winner's arvalid.
  task automatic serve_read(input logic to_lsu, input logic [AW-1:0] exp_addr,
                            input logic [DW-1:0] data, input logic [1:0] resp,
                            input int ar_stall, input int r_stall);
    int n;
    logic [AW-1:0] held;
    n = 0;
    while (!arvalid && n < 10) begin
      step();
      n++;
    end
    check("ar_wait", arvalid, 1);
    check("araddr", araddr, exp_addr);
    held = araddr;
    for (int k = 0; k < ar_stall; k++) begin
      check("ar_stall_valid", arvalid, 1);
      check("ar_stall_addr", araddr, held);
      check("ar_stall_state", dbg_r, 3);
      step();
    end
    arready = 1'b1;
    #1;
    check("arready_win", to_lsu ? lsu_arready : ifu_arready, 1);
    check("arready_lose", to_lsu ? ifu_arready : lsu_arready, 0);
    step();
    arready = 1'b0;
    if (to_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    rvalid = 1'b1;
    rdata = data;
    rresp = resp;
    exp_q.push_back(data);
    if (to_lsu) lsu_rready = (r_stall == 0); else ifu_rready = (r_stall == 0);
    #1;
    for (int k = 0; k < r_stall; k++) begin
      check("r_hold_state", dbg_r, 4);
      check("r_hold_rready", rready, 0);
      check("r_hold_valid", to_lsu ? lsu_rvalid : ifu_rvalid, 1);
      step();
    end
    if (to_lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
    #1;
    check("r_win_valid", to_lsu ? lsu_rvalid : ifu_rvalid, 1);
    check("r_lose_valid", to_lsu ? ifu_rvalid : lsu_rvalid, 0);
    check("rdata", to_lsu ? lsu_rdata : ifu_rdata, exp_q.pop_front());
    check("rresp", to_lsu ? lsu_rresp : ifu_rresp, resp);
    check("rready", rready, 1);
    step();
    rvalid = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    ifu_rready = 1'b0;
    lsu_rready = 1'b0;
    #1;
    check("r_back_idle", dbg_r, 0);
  endtask

  typedef struct {
    logic          to_lsu;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            ar_stall;
    int            r_stall;
  } rd_vec_t;

  rd_vec_t vecs[4];
  logic tb_last_lsu;

  task automatic tie_read(input logic [AW-1:0] ia, input logic [AW-1:0] la);
    logic first_lsu;
`ifdef ARB_ROUND_ROBIN_EN
    first_lsu = ~tb_last_lsu;
`else
    first_lsu = 1'b1;
`endif
    ifu_arvalid = 1'b1;
    ifu_araddr = ia;
    lsu_arvalid = 1'b1;
    lsu_araddr = la;
    serve_read(first_lsu, first_lsu ? la : ia, {$urandom, $urandom}, 2'b00, 0, 0);
    serve_read(~first_lsu, first_lsu ? ia : la, {$urandom, $urandom}, 2'b01, 0, 0);
    tb_last_lsu = ~first_lsu;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready} = '0;
    {lsu_awvalid, lsu_wvalid, lsu_bready} = '0;
    ifu_araddr = '0; lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    {arready, rvalid, awready, wready, bvalid} = '0;
    rresp = '0; bresp = '0; rdata = '0;
    tb_last_lsu = 1'b1;

    vecs[0] = '{1'b0, 32'h3000_0000, 64'h0000_0013_0000_0013, 2'b00, 0, 0};
    vecs[1] = '{1'b1, 32'h0f00_0010, {$urandom, $urandom}, 2'b10, 0, 0};
    vecs[2] = '{1'b0, 32'h3000_0040, {$urandom, $urandom}, 2'b00, 5, 3};
    vecs[3] = '{1'b1, 32'h0f00_0ff8, {$urandom, $urandom}, 2'b11, $urandom_range(1, 3), $urandom_range(1, 2)};

    step();
    step();
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_ifu_arready", ifu_arready, 0);
    check("rst_lsu_bvalid", lsu_bvalid, 0);
    check("rst_r_state", dbg_r, 0);
    check("rst_w_state", dbg_w, 0);
    rst_n = 1'b1;
    step();

    // IDLE outputs stay low with XBAR inputs asserted
    rvalid = 1'b1; arready = 1'b1; bvalid = 1'b1; #1;
    check("idle_ifu_rvalid", ifu_rvalid, 0);
    check("idle_lsu_rvalid", lsu_rvalid, 0);
    check("idle_lsu_bvalid", lsu_bvalid, 0);
    rvalid = 1'b0; arready = 1'b0; bvalid = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].to_lsu) begin
        lsu_arvalid = 1'b1;
        lsu_araddr = vecs[i].addr;
      end else begin
        ifu_arvalid = 1'b1;
        ifu_araddr = vecs[i].addr;
      end
      serve_read(vecs[i].to_lsu, vecs[i].addr, vecs[i].data, vecs[i].resp,
                 vecs[i].ar_stall, vecs[i].r_stall);
    end

    tie_read(32'h3000_0004, 32'h0f00_0000);
    tie_read(32'h3000_0008, 32'h0f00_0008);

    // Reset in the middle of R_DATA
    ifu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0100;
    step(); step();
    check("rst_seq_arvalid", arvalid, 1);
    arready = 1'b1;
    step();
    arready = 1'b0; ifu_arvalid = 1'b0;
    rvalid = 1'b1; rdata = 64'hdead_beef_0000_0001; ifu_rready = 1'b0;
    #1;
    check("rst_seq_rvalid_before", ifu_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ifu_rvalid", ifu_rvalid, 0);
    check("rst_async_rready", rready, 0);
    check("rst_async_state", dbg_r, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_ifu_rvalid", ifu_rvalid, 0);
    check("post_rst_lsu_rvalid", lsu_rvalid, 0);
    check("post_rst_state", dbg_r, 0);
    rvalid = 1'b0; rdata = '0;
    step();

    // Write with W ahead of AW, IFU read while B is stalled
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h1000_0000;
    lsu_wvalid = 1'b1; lsu_wdata = 64'h0123_4567_89ab_cdef; lsu_wstrb = 8'h01;
    lsu_bready = 1'b1;
    #1;
    check("wr_idle_awvalid", awvalid, 0);
    step();
    check("wr_addr_state", dbg_w, 1);
    check("wr_awvalid", awvalid, 1);
    check("wr_wvalid", wvalid, 1);
    wready = 1'b1;
    #1;
    check("wr_lsu_wready", lsu_wready, 1);
    check("wr_wdata", wdata, 64'h0123_4567_89ab_cdef);
    check("wr_wstrb", wstrb, 8'h01);
    check("wr_lsu_awready_early", lsu_awready, 0);
    step();
    wready = 1'b0; lsu_wvalid = 1'b0;
    #1;
    check("wr_w_masked", wvalid, 0);
    step();
    awready = 1'b1;
    #1;
    check("wr_awaddr", awaddr, 32'h1000_0000);
    check("wr_lsu_awready", lsu_awready, 1);
    step();
    awready = 1'b0; lsu_awvalid = 1'b0;
    #1;
    check("wr_resp_state", dbg_w, 2);
    check("wr_resp_bready", bready, 1);
    check("wr_resp_awvalid", awvalid, 0);
    ifu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0008;
    serve_read(1'b0, 32'h3000_0008, {$urandom, $urandom}, 2'b00, 1, 0);
    check("wr_stalled_bvalid", lsu_bvalid, 0);
    check("wr_stalled_state", dbg_w, 2);
    bvalid = 1'b1; bresp = 2'b10;
    #1;
    check("wr_lsu_bvalid", lsu_bvalid, 1);
    check("wr_lsu_bresp", lsu_bresp, 2'b10);
    step();
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    check("wr_done_state", dbg_w, 0);
    check("wr_aw_beats", aw_beats, 1);
    check("wr_w_beats", w_beats, 1);

    // AW and W handshake together, immediate response
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h1000_0040;
    lsu_wvalid = 1'b1; lsu_wdata = {$urandom, $urandom}; lsu_wstrb = 8'hf0;
    step();
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    #1;
    check("wr2_resp_state", dbg_w, 2);
    check("wr2_awvalid", awvalid, 0);
    bvalid = 1'b1;
    #1;
    check("wr2_lsu_bvalid", lsu_bvalid, 1);
    step();
    bvalid = 1'b0;
    #1;
    check("wr2_idle", dbg_w, 0);
    check("wr2_aw_beats", aw_beats, 2);
    check("wr2_w_beats", w_beats, 2);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
